mmio_bus_bridge: RTL



---
 rtl/mmio_bus_bridge.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mmio_bus_bridge.sv
// Memory-side bridge: decodes datapath accesses to external RAM or a peripheral page
// (GPIO out/in, prescaled timer). Timer is built only when MMIO_TIMER_EN is defined.
module mmio_bus_bridge #(
    parameter int GPIO_W   = 8,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       adr,
    input  logic [31:0]       writedata,
    input  logic              memwrite,
    output logic [31:0]       readdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    typedef enum logic [2:0] {
        REG_GPIO_OUT     = 3'd0,
        REG_GPIO_IN      = 3'd1,
        REG_TIMER_COUNT  = 3'd2,
        REG_TIMER_CMP    = 3'd3,
        REG_TIMER_STATUS = 3'd4
    } reg_sel_e;

    logic              periph_sel;
    logic              page_ok;
    reg_sel_e          reg_idx;
    logic              wr_gpio;
    logic [GPIO_W-1:0] gpio_sync1;
    logic [GPIO_W-1:0] gpio_sync2;
    logic              unused_bits;

    assign periph_sel = (adr[31:12] == 20'h00001);
    // Only the first eight words of the page are registers; the rest of the page reads 0.
    assign page_ok    = periph_sel && (adr[11:5] == 7'd0);
    assign reg_idx    = reg_sel_e'(adr[4:2]);
    assign ram_we     = memwrite && !periph_sel;
    assign wr_gpio    = memwrite && page_ok && (reg_idx == REG_GPIO_OUT);
    assign unused_bits = ^{adr[1:0], writedata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out   <= '0;
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            if (wr_gpio)
                gpio_out <= writedata[GPIO_W-1:0];
        end
    end

`ifdef MMIO_TIMER_EN
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        match;
    logic        en;
    logic        tick;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_status;

    assign tick      = en && (presc == PRESC_LAST);
    assign wr_count  = memwrite && page_ok && (reg_idx == REG_TIMER_COUNT);
    assign wr_cmp    = memwrite && page_ok && (reg_idx == REG_TIMER_CMP);
    assign wr_status = memwrite && page_ok && (reg_idx == REG_TIMER_STATUS);
    assign timer_irq = match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            count <= '0;
            cmp   <= '1;
            match <= 1'b0;
            en    <= 1'b0;
        end else begin
            if (!en || tick)
                presc <= '0;
            else
                presc <= presc + 16'd1;

            if (wr_cmp)
                cmp <= writedata;
            if (wr_status)
                en <= writedata[1];

            // A software COUNT write suppresses both the increment and the match check;
            // a hardware match set takes precedence over a W1C in the same edge.
            if (wr_count) begin
                count <= writedata;
                if (wr_status && writedata[0])
                    match <= 1'b0;
            end else if (tick && (count == cmp)) begin
                count <= '0;
                match <= 1'b1;
            end else begin
                if (tick)
                    count <= count + 32'd1;
                if (wr_status && writedata[0])
                    match <= 1'b0;
            end
        end
    end
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        if (!periph_sel) begin
            readdata = ram_rdata;
        end else if (page_ok) begin
            case (reg_idx)
                REG_GPIO_OUT:     readdata[GPIO_W-1:0] = gpio_out;
                REG_GPIO_IN:      readdata[GPIO_W-1:0] = gpio_sync2;
`ifdef MMIO_TIMER_EN
                REG_TIMER_COUNT:  readdata = count;
                REG_TIMER_CMP:    readdata = cmp;
                REG_TIMER_STATUS: readdata[1:0] = {en, match};
`endif
                default:          readdata = '0;
            endcase
        end
    end

endmodule
